ram_nr1w_sync: RTL and testbench
================================

Name: ram_nr1w_sync

Overview:
Synthesizable, parametrised successor to the DPI-backed 2-read/1-write memory model. It provides NR independent read ports and one byte-strobed write port over an internal DEPTH x DATA_W array. Reads are registered, with a valid/ready handshake per port, write-first forwarding and range checking. It sits between the core's fetch/LSU stages and on-chip RAM; imem uses port 0 and dmem uses port 1 when NR=2.

Parameters:
NR, 2, number of read ports (1..4)
DATA_W, 32, word width in bits (32 or 64)
DEPTH, 1024, words of storage (power of two)
ADDR_W, 32, byte-address width
BASE, 32'h8000_0000, byte address of word 0 (aligned to DEPTH*DATA_W/8)

Ports:
clock  in  1  sole clock, all state on rising edge
reset  in  1  synchronous, active-high
rd_req_valid  in  NR  per-port read request
rd_req_ready  out  NR  per-port request accept
rd_addr  in  NR*ADDR_W  per-port byte address; port i at [i*ADDR_W +: ADDR_W]
rd_resp_valid  out  NR  response valid
rd_resp_ready  in  NR  response consume
rd_resp_data  out  NR*DATA_W  read data, packed as for rd_addr
rd_resp_err  out  NR  address out of range; data is 0
wr_en  in  1  write request, always accepted
wr_addr  in  ADDR_W  byte address
wr_strb  in  DATA_W/8  byte enables
wr_data  in  DATA_W  write data
wr_err  out  1  one-cycle pulse, the cycle after an out-of-range write

Behaviour:
- Reset: rd_resp_valid=0, rd_resp_data=0, rd_resp_err=0, wr_err=0. rd_req_ready=1 in the cycle after reset deasserts. Array contents are not reset.
- Reset mid-operation: pending and held responses are dropped. A write presented in a reset cycle is ignored.
- Address decode: off = addr - BASE. Word index = off[ADDR_LO +: IDX_W], where ADDR_LO = log2(DATA_W/8) and IDX_W = log2(DEPTH). Low ADDR_LO bits are ignored (misalignment is not an error). In range iff addr >= BASE and off < DEPTH*DATA_W/8.
- Read handshake, per port and independent: rd_req_ready[i] = !rd_resp_valid[i] || rd_resp_ready[i]. The request is accepted when valid && ready. The response registers on the next edge, giving 1-cycle latency. Back-to-back accepts give 1 response per cycle.
- Held response: while rd_resp_valid && !rd_resp_ready, data and err stay stable. Later writes to the same word do not alter a held response.
- Out-of-range read: err=1, data=0, handshake unchanged.
- Write: in-range writes update only the bytes whose strobe bit is 1, on the edge. wr_strb=0 is a no-op and not an error. Out-of-range writes are dropped and wr_err=1 for the following cycle.
- Write-first forwarding: if a read is accepted in the same cycle as an in-range write to the same word, the response returns the byte-merged new value.
- Simultaneous reads: multiple ports reading the same word in the same cycle all receive identical data.
- No internal stalls: the write port has no ready signal, and reads never block writes.

Decomposition:
- Package ram_pkg:
  - localparams ADDR_LO and IDX_W as functions of DATA_W/DEPTH.
  - function in_range(addr).
  - function strb_merge(old, new, strb) for byte merge.
  - typedef for the decoded index.
- Sub-module ram_rd_port, instantiated NR times:
  - holds the request-accept logic, the output register for data/err/valid, and the forwarding mux.
  - receives the array word, the write-compare inputs and the decoded in-range flag.
- Top level holds the storage array, write decode and wr_err.

Test Plan:
- Write 0xDEADBEEF to 0x8000_0010 with strb=0xF; next cycle read on port 0 -> one cycle later resp_valid=1, data=0xDEADBEEF, err=0.
- Same cycle: write 0x11223344 with strb=0x3 to word 0x8000_0010 (old 0xDEADBEEF) and read it on ports 0 and 1 -> both responses return 0xDEAD3344.
- Port 1 response held with resp_ready=0 for 3 cycles while 0x0 is written to its word -> data stays at the old value, rd_req_ready[1]=0, and port 0 keeps streaming 1 response per cycle.
- Read 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> err=1 and data=0 for each. Write to 0x8000_1000 -> wr_err pulses for 1 cycle and the array is unchanged.
- Assert reset while port 0 holds a valid response -> next cycle resp_valid=0, data=0. A write issued during reset leaves the target word unchanged.
- Read 0x8000_0013 after writing 0xCAFEF00D to 0x8000_0010 -> returns 0xCAFEF00D (low bits ignored).

Source files
------------

// File: rtl/ram_nr1w_sync_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared decode helpers for the ram_nr1w_sync memory.
//   addr_lo()     byte-offset bits inside one word (log2(DATA_W/8))
//   idx_w()       word-index width (log2(DEPTH))
//   in_range()    byte address lies inside [base, base+span)
//   word_index()  word index of a byte address relative to base
//   strb_merge()  byte-strobed merge of a new word over an old word
// Addresses and words travel as 64-bit values so that a single helper serves
// every legal ADDR_W/DATA_W; callers cast back to their own widths.
// ----------------------------------------------------------------------------
package ram_pkg;

   // Decoded word index before truncation to the real index width.
   typedef logic [31:0] word_idx_t;

   function automatic int unsigned addr_lo(input int unsigned data_w);
      return $clog2(data_w / 32'd8);
   endfunction

   function automatic int unsigned idx_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic logic in_range(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
      return (addr >= base) && ((addr - base) < span);
   endfunction

   // Misaligned low bits are simply shifted away.
   function automatic word_idx_t word_index(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input int unsigned lo);
      return word_idx_t'((addr - base) >> lo);
   endfunction

   function automatic logic [63:0] strb_merge(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = old_w;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_w[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_w[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_nr1w_sync_if.sv
// ----------------------------------------------------------------------------
// ram_nr1w_sync_if
// Bus bundle for ram_nr1w_sync: NR read request/response channels
// (valid/ready each way, ports packed i*ADDR_W / i*DATA_W) and one
// always-accepted byte-strobed write channel with its wr_err pulse.
//   master : requester side (fetch/LSU or testbench)
//   slave  : memory side
// ----------------------------------------------------------------------------
interface ram_nr1w_sync_if #(
   parameter int NR     = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();
   logic [NR-1:0]        rd_req_valid;
   logic [NR-1:0]        rd_req_ready;
   logic [NR*ADDR_W-1:0] rd_addr;
   logic [NR-1:0]        rd_resp_valid;
   logic [NR-1:0]        rd_resp_ready;
   logic [NR*DATA_W-1:0] rd_resp_data;
   logic [NR-1:0]        rd_resp_err;
   logic                 wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [DATA_W/8-1:0]  wr_strb;
   logic [DATA_W-1:0]    wr_data;
   logic                 wr_err;

   modport master (
      output rd_req_valid, rd_addr, rd_resp_ready,
      output wr_en, wr_addr, wr_strb, wr_data,
      input  rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err, wr_err
   );

   modport slave (
      input  rd_req_valid, rd_addr, rd_resp_ready,
      input  wr_en, wr_addr, wr_strb, wr_data,
      output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err, wr_err
   );
endinterface

// File: rtl/ram_nr1w_sync_rd_port.sv
// ----------------------------------------------------------------------------
// ram_rd_port
// One registered read port of ram_nr1w_sync.
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready = !resp_valid || resp_ready)
//   in_range_i, rd_idx_i  decoded request address
//   arr_word_i            array word at rd_idx_i
//   wr_hit_i, wr_idx_i,
//   wr_strb_i, wr_data_i  same-cycle in-range write, for write-first forwarding
//   resp_ready_i          response consume
//   resp_valid_o/data_o/
//   resp_err_o            registered response
// ----------------------------------------------------------------------------
module ram_rd_port
   import ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                in_range_i,
   input  logic [IDX_W-1:0]    rd_idx_i,
   input  logic [DATA_W-1:0]   arr_word_i,
   input  logic                wr_hit_i,
   input  logic [IDX_W-1:0]    wr_idx_i,
   input  logic [DATA_W/8-1:0] wr_strb_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic                resp_ready_i,
   output logic                resp_valid_o,
   output logic [DATA_W-1:0]   resp_data_o,
   output logic                resp_err_o
);
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] fwd_word_s;
   logic              accept_s;

   assign req_ready_o = !valid_q || resp_ready_i;
   // Nothing is accepted while reset is held, so no response survives it.
   assign accept_s    = req_valid_i && req_ready_o && !rst_i;

   // Write-first: a write landing on this word in the same cycle wins.
   always_comb begin
      fwd_word_s = arr_word_i;
      if (wr_hit_i && (wr_idx_i == rd_idx_i)) begin
         fwd_word_s = DATA_W'(strb_merge(64'(arr_word_i), 64'(wr_data_i),
                                         8'(wr_strb_i)));
      end else begin
         fwd_word_s = arr_word_i;
      end
   end

   // Response next-state: load on accept, retire on consume, else hold.
   always_comb begin
      valid_d = valid_q;
      err_d   = err_q;
      data_d  = data_q;
      if (accept_s) begin
         valid_d = 1'b1;
         err_d   = !in_range_i;
         data_d  = in_range_i ? fwd_word_s : {DATA_W{1'b0}};
      end else if (resp_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Response register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= {DATA_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign resp_valid_o = valid_q;
   assign resp_data_o  = data_q;
   assign resp_err_o   = err_q;
endmodule

// File: rtl/ram_nr1w_sync.sv
// ----------------------------------------------------------------------------
// ram_nr1w_sync
// NR-read / 1-write synchronous RAM of DEPTH x DATA_W words mapped at BASE.
//   clock  sole clock, all state on the rising edge
//   reset  synchronous, active-high; array contents are not reset
//   bus    ram_nr1w_sync_if.slave: NR registered read ports with valid/ready,
//          one byte-strobed write port, wr_err pulse after an out-of-range write
// ----------------------------------------------------------------------------
module ram_nr1w_sync
   import ram_pkg::*;
#(
   parameter int                NR     = 2,
   parameter int                DATA_W = 32,
   parameter int                DEPTH  = 1024,
   parameter int                ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
) (
   input logic             clock,
   input logic             reset,
   ram_nr1w_sync_if.slave  bus
);
   localparam int          ADDR_LO = addr_lo(DATA_W);
   localparam int          IDX_W   = idx_w(DEPTH);
   localparam logic [63:0] BASE_X  = 64'(BASE);
   localparam logic [63:0] SPAN    = 64'(DEPTH) * 64'(DATA_W / 8);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [63:0]       wr_addr_s;
   logic              wr_in_range_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic              wr_hit_s;
   logic              wr_oor_s;
   logic              wr_err_q;

   logic [NR-1:0]        req_ready_s;
   logic [NR-1:0]        resp_valid_s;
   logic [NR-1:0]        resp_err_s;
   logic [NR*DATA_W-1:0] resp_data_s;

   assign wr_addr_s     = 64'(bus.wr_addr);
   assign wr_in_range_s = in_range(wr_addr_s, BASE_X, SPAN);
   assign wr_idx_s      = IDX_W'(word_index(wr_addr_s, BASE_X, ADDR_LO));
   // Writes presented during reset are ignored entirely.
   assign wr_hit_s      = bus.wr_en && wr_in_range_s && !reset;
   assign wr_oor_s      = bus.wr_en && !wr_in_range_s && !reset;

   // Byte-enabled array write; storage is deliberately not reset.
   always_ff @(posedge clock) begin
      if (wr_hit_s) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (bus.wr_strb[b]) begin
               mem_q[wr_idx_s][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Out-of-range write flag, a single-cycle pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_oor_s;
      end
   end

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [63:0]       rd_addr_s;
      logic              rd_in_range_s;
      logic [IDX_W-1:0]  rd_idx_s;
      logic [DATA_W-1:0] arr_word_s;

      assign rd_addr_s     = 64'(bus.rd_addr[i*ADDR_W +: ADDR_W]);
      assign rd_in_range_s = in_range(rd_addr_s, BASE_X, SPAN);
      assign rd_idx_s      = IDX_W'(word_index(rd_addr_s, BASE_X, ADDR_LO));
      assign arr_word_s    = mem_q[rd_idx_s];

      ram_rd_port #(
         .DATA_W (DATA_W),
         .IDX_W  (IDX_W)
      ) u_rd_port (
         .clk_i        (clock),
         .rst_i        (reset),
         .req_valid_i  (bus.rd_req_valid[i]),
         .req_ready_o  (req_ready_s[i]),
         .in_range_i   (rd_in_range_s),
         .rd_idx_i     (rd_idx_s),
         .arr_word_i   (arr_word_s),
         .wr_hit_i     (wr_hit_s),
         .wr_idx_i     (wr_idx_s),
         .wr_strb_i    (bus.wr_strb),
         .wr_data_i    (bus.wr_data),
         .resp_ready_i (bus.rd_resp_ready[i]),
         .resp_valid_o (resp_valid_s[i]),
         .resp_data_o  (resp_data_s[i*DATA_W +: DATA_W]),
         .resp_err_o   (resp_err_s[i])
      );
   end

   assign bus.rd_req_ready  = req_ready_s;
   assign bus.rd_resp_valid = resp_valid_s;
   assign bus.rd_resp_data  = resp_data_s;
   assign bus.rd_resp_err   = resp_err_s;
   assign bus.wr_err        = wr_err_q;
endmodule

// File: tb/tb_ram_nr1w_sync.sv
// ----------------------------------------------------------------------------
// tb_ram_nr1w_sync
// Directed bench for ram_nr1w_sync (NR=2, DATA_W=32, DEPTH=1024).
// A reference memory and per-port handshake model predict each response;
// predictions are queued when a request is accepted and compared while the
// DUT presents the response.
// ----------------------------------------------------------------------------
module tb_ram_nr1w_sync;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ram_nr1w_sync_if #(.NR(2), .DATA_W(32), .ADDR_W(32)) bus ();

   ram_nr1w_sync #(
      .NR(2), .DATA_W(32), .DEPTH(1024), .ADDR_W(32), .BASE(32'h8000_0000)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // stimulus for the next cycle
   logic [1:0]  s_req, s_rdy;
   logic [31:0] s_addr [2];
   logic        s_wen, s_rst;
   logic [31:0] s_waddr, s_wdata;
   logic [3:0]  s_wstrb;

   // reference model
   logic [31:0] mdl [1024];
   logic [1:0]  mvalid;
   logic        exp_wr_err;
   logic        rst_prev;
   logic [32:0] q0 [$];
   logic [32:0] q1 [$];

   int errors = 0;
   int checks = 0;

   function automatic bit mdl_inr(input logic [31:0] a);
      return (a >= 32'h8000_0000) && (a < 32'h8000_1000);
   endfunction

   function automatic logic [9:0] mdl_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'h8000_0000;
      return off[11:2];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      s_req = 2'b00; s_rdy = 2'b11; s_wen = 1'b0; s_rst = 1'b0;
      s_waddr = 32'h8000_0000; s_wdata = 32'h0; s_wstrb = 4'h0;
   endtask

   // Apply stimulus, check DUT state mid-cycle, advance model across the edge.
   task automatic cyc();
      logic [32:0] e;
      logic        rdy, acc;
      logic [9:0]  ix;
      reset             = s_rst;
      bus.rd_req_valid  = s_req;
      bus.rd_resp_ready = s_rdy;
      bus.rd_addr       = {s_addr[1], s_addr[0]};
      bus.wr_en         = s_wen;
      bus.wr_addr       = s_waddr;
      bus.wr_data       = s_wdata;
      bus.wr_strb       = s_wstrb;
      #3;
      for (int i = 0; i < 2; i++) begin
         rdy = !mvalid[i] || s_rdy[i];
         chk($sformatf("req_ready%0d", i), 32'(bus.rd_req_ready[i]), 32'(rdy));
         chk($sformatf("resp_valid%0d", i), 32'(bus.rd_resp_valid[i]), 32'(mvalid[i]));
         if (mvalid[i]) begin
            if (i == 0) e = q0[0]; else e = q1[0];
            chk($sformatf("resp_data%0d", i), bus.rd_resp_data[i*32 +: 32], e[31:0]);
            chk($sformatf("resp_err%0d", i), 32'(bus.rd_resp_err[i]), 32'(e[32]));
            if (s_rdy[i]) begin
               if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
         end else if (rst_prev) begin
            chk($sformatf("rst_data%0d", i), bus.rd_resp_data[i*32 +: 32], 32'h0);
            chk($sformatf("rst_err%0d", i), 32'(bus.rd_resp_err[i]), 32'h0);
         end
      end
      chk("wr_err", 32'(bus.wr_err), 32'(exp_wr_err));
      if (s_rst) begin
         q0.delete(); q1.delete();
         mvalid = 2'b00;
         exp_wr_err = 1'b0;
      end else begin
         exp_wr_err = 1'b0;
         if (s_wen) begin
            if (mdl_inr(s_waddr)) begin
               ix = mdl_idx(s_waddr);
               for (int b = 0; b < 4; b++)
                  if (s_wstrb[b]) mdl[ix][b*8 +: 8] = s_wdata[b*8 +: 8];
            end else begin
               exp_wr_err = 1'b1;
            end
         end
         for (int i = 0; i < 2; i++) begin
            rdy = !mvalid[i] || s_rdy[i];
            acc = s_req[i] && rdy;
            if (acc) begin
               if (mdl_inr(s_addr[i])) e = {1'b0, mdl[mdl_idx(s_addr[i])]};
               else                    e = {1'b1, 32'h0};
               if (i == 0) q0.push_back(e); else q1.push_back(e);
            end
            mvalid[i] = acc || (mvalid[i] && !s_rdy[i]);
         end
      end
      rst_prev = s_rst;
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
      s_wen = 1'b1; s_waddr = a; s_wdata = d; s_wstrb = st;
   endtask

   initial begin
      s_addr[0] = 32'h8000_0000; s_addr[1] = 32'h8000_0000;
      idle();
      s_rst = 1'b1;
      reset = 1'b1;
      bus.rd_req_valid = 2'b00; bus.rd_resp_ready = 2'b11; bus.rd_addr = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
      repeat (2) @(posedge clock);
      #1;
      mvalid = 2'b00; exp_wr_err = 1'b0; rst_prev = 1'b1;

      // post-reset state, then preload two words
      idle(); cyc();
      idle(); wr(32'h8000_0000, 32'h0123_4567, 4'hF); cyc();
      idle(); wr(32'h8000_0014, 32'h55AA_55AA, 4'hF); cyc();

      // basic write then read
      idle(); wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF); cyc();
      idle(); s_req = 2'b01; s_addr[0] = 32'h8000_0010; cyc();
      idle(); cyc();

      // partial write forwarded to both ports in the same cycle
      idle(); wr(32'h8000_0010, 32'h1122_3344, 4'h3);
      s_req = 2'b11; s_addr[0] = 32'h8000_0010; s_addr[1] = 32'h8000_0010; cyc();
      chk("fwd_p0", bus.rd_resp_data[31:0], 32'hDEAD_3344);
      chk("fwd_p1", bus.rd_resp_data[63:32], 32'hDEAD_3344);
      idle(); cyc();

      // port 1 held for 3 cycles while its word is overwritten; port 0 streams
      idle(); s_req = 2'b10; s_addr[1] = 32'h8000_0010; cyc();
      for (int k = 0; k < 3; k++) begin
         idle(); s_rdy = 2'b01; s_req = 2'b11;
         s_addr[0] = 32'h8000_0010; s_addr[1] = 32'h8000_0014;
         if (k == 0) wr(32'h8000_0010, 32'h0000_0000, 4'hF);
         cyc();
         chk("held_p1", bus.rd_resp_data[63:32], 32'hDEAD_3344);
      end
      idle(); cyc();
      idle(); cyc();

      // out-of-range reads and write
      idle(); s_req = 2'b11; s_addr[0] = 32'h7FFF_FFFC; s_addr[1] = 32'h8000_1000; cyc();
      idle(); wr(32'h8000_1000, 32'hFFFF_FFFF, 4'hF); cyc();
      idle(); cyc();
      idle(); cyc();
      idle(); s_req = 2'b01; s_addr[0] = 32'h8000_0000; cyc();
      idle(); cyc();

      // reset while a response is held; write during reset is dropped
      idle(); s_rdy = 2'b00; s_req = 2'b01; s_addr[0] = 32'h8000_0014; cyc();
      idle(); s_rdy = 2'b00; cyc();
      idle(); s_rdy = 2'b00; s_rst = 1'b1; wr(32'h8000_0010, 32'hBADB_AD00, 4'hF); cyc();
      idle(); cyc();
      idle(); s_req = 2'b01; s_addr[0] = 32'h8000_0010; cyc();
      idle(); cyc();

      // misaligned read, zero-strobe write
      idle(); wr(32'h8000_0010, 32'hCAFE_F00D, 4'hF); cyc();
      idle(); wr(32'h8000_0010, 32'hFFFF_FFFF, 4'h0); cyc();
      idle(); s_req = 2'b10; s_addr[1] = 32'h8000_0013; cyc();
      chk("misalign_p1", bus.rd_resp_data[63:32], 32'hCAFE_F00D);
      idle(); cyc();
      idle(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
